trng_sampler: RTL and testbench
===============================

// Module: trng_sampler
// PURPOSE
//   Multi-channel entropy harvester for the iCE40 TRNG. Samples N_CH free-running ring-oscillator
//   nets (asynchronous to clk), XOR-combines them and removes bias with a von Neumann corrector.
//   Packs the result into WIDTH-bit words on a valid/ready stream. A sticky repetition-count
//   health test shuts the output off if the raw source sticks.
// PARAMETERS
//   N_CH        4   number of entropy inputs (>=1)
//   WIDTH       8   output word width in bits (>=2)
//   SYNC_STAGES 2   synchroniser flops per input (>=2)
//   RCT_LIMIT   32  consecutive identical raw bits that trip health_fail (>=2)
// PORTS
//   clk          in   1        system clock
//   rst          in   1        synchronous, active-high reset
//   en           in   1        sampling enable
//   ro_in        in   N_CH     asynchronous oscillator inputs; keep through synthesis
//   out_data     out  WIDTH    packed random word
//   out_valid    out  1        out_data holds a word
//   out_ready    in   1        consumer accepts the word
//   health_fail  out  1        sticky repetition-count failure
// BEHAVIOUR
//   Reset: all flops clear to 0, including syncs, raw_bit, pair state, accumulator and counters.
//     out_data=0, out_valid=0, health_fail=0.
//   Sync: each ro_in[i] passes through SYNC_STAGES flops. raw_bit <= XOR of all synced bits.
//     raw_valid is high every cycle en=1. Latency ro_in -> raw_bit is SYNC_STAGES+1 cycles.
//   en=0: synchronisers keep running; raw_valid=0; pair state returns to FIRST.
//     Accumulator contents and the output word are held.
//   Von Neumann FSM, consumes raw_valid samples:
//     FIRST: store bit a -> SECOND.
//     SECOND: take bit b -> FIRST. a!=b emits bit a (10->1, 01->0); a==b emits nothing.
//   Accumulator: each emitted bit is shifted in at the LSB (acc <= {acc[WIDTH-2:0], bit}).
//     cnt increments per bit. When cnt reaches WIDTH, acc is full and cnt stays at WIDTH.
//   Output transfer happens on a clk edge where out_valid & out_ready.
//     When out_valid=0 or a transfer occurs, and acc is full: out_data<=acc, out_valid<=1,
//       cnt<=0 on that edge. Back-to-back words are allowed.
//     A transfer with acc not full sets out_valid<=0.
//     out_data is stable while out_valid=1 and out_ready=0.
//   Backpressure: when acc is full and it cannot move to the output, new emitted bits are
//     dropped (no overwrite). The FSM keeps running.
//   Bit count and word load on the same edge: the load takes priority.
//     The emitted bit is dropped if acc was full; otherwise it is shifted in first and the load
//     happens on the next edge.
//   Health RCT, on raw_valid samples:
//     A raw bit equal to the previous one gives rep<=rep+1, otherwise rep<=1.
//     When rep reaches RCT_LIMIT, health_fail<=1 and stays 1 until rst.
//     The same edge clears out_valid and cnt. All further output is suppressed.
//     rep saturates at RCT_LIMIT. en=0 does not clear rep.
//   Reset mid-word or mid-transfer: the partial word is lost and out_valid drops next edge.
//     No word is output after reset until WIDTH new debiased bits have been collected.
// TESTING
//   1. N_CH=1, en=1, raw pairs 1,0 repeated 8 times, out_ready=1 -> one word 8'hFF, out_valid
//      high for 1 cycle.
//   2. Raw pairs 0,1 x4 interleaved with 0,0 and 1,1 pairs x4 -> exactly one word 8'h00 after
//      4 more 01 pairs. No word from the equal pairs.
//   3. out_ready=0, feed 24 emitted bits (0xA5, 0x3C, then 8 more) -> out_data=8'hA5 held
//      stable, acc=8'h3C, third byte dropped. Pulse ready: next cycle out_data=8'h3C, then
//      out_valid=0.
//   4. ro_in held at 0 with en=1 -> health_fail=1 after 32 raw samples (+SYNC_STAGES+1
//      latency). out_valid=0, no words for 200 cycles. rst clears it.
//   5. N_CH=2, ch0=ch1 toggling together -> raw_bit constant 0, RCT trips.
//      ch1 inverted instead -> raw_bit constant 1, also trips.
//   6. rst pulse after 5 of 8 bits -> cnt=0, no word until 8 fresh bits.
//      en low mid-pair -> pairing restarts and acc is retained.

Source files
------------

// File: rtl/trng_sampler.sv
// trng_sampler: multi-channel ring-oscillator entropy harvester.
// Synchronises N_CH asynchronous oscillator nets, XOR-combines them into one raw
// bit per cycle, debiases with a von Neumann corrector, packs WIDTH-bit words onto
// a valid/ready stream and runs a sticky repetition-count health test on the raw bit.
module trng_sampler #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RCT_LIMIT   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_CH-1:0]  ro_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned REP_W = $clog2(RCT_LIMIT + 1);

  typedef enum logic {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } vn_state_t;

  // Stage-major synchroniser array: sync_q[0] is the metastability-exposed stage.
  (* keep = "true", async_reg = "true" *)
  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic             raw_bit;
  logic             raw_valid;

  vn_state_t        state;
  vn_state_t        state_next;
  logic             a_q;
  logic             emit_valid;
  logic             emit_bit;

  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             acc_full;
  logic             xfer;
  logic             load;
  logic             kill;

  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] rep_next;
  logic             prev_raw;
  logic             rct_trip;

  // Synchronisers run regardless of en so the raw pipeline is always primed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= ro_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Raw entropy bit: XOR of every synchronised channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_bit <= 1'b0;
    end else begin
      raw_bit <= ^sync_q[SYNC_STAGES-1];
    end
  end

  assign raw_valid = en;

  // Von Neumann pair state register; also captures the first bit of each pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FIRST;
      a_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (raw_valid && (state == ST_FIRST)) begin
        a_q <= raw_bit;
      end
    end
  end

  // Pair sequencing; dropping en abandons any half-collected pair.
  always_comb begin
    state_next = state;
    if (!raw_valid) begin
      state_next = ST_FIRST;
    end else begin
      case (state)
        ST_FIRST:  state_next = ST_SECOND;
        ST_SECOND: state_next = ST_FIRST;
        default:   state_next = ST_FIRST;
      endcase
    end
  end

  // Emit the first bit of an unequal pair (10 -> 1, 01 -> 0).
  always_comb begin
    emit_valid = 1'b0;
    emit_bit   = a_q;
    if (raw_valid && (state == ST_SECOND) && (raw_bit != a_q)) begin
      emit_valid = 1'b1;
    end
  end

  // Repetition count on raw samples, saturating at RCT_LIMIT.
  always_comb begin
    rep_next = REP_W'(1);
    if (raw_bit == prev_raw) begin
      if (rep == REP_W'(RCT_LIMIT)) begin
        rep_next = rep;
      end else begin
        rep_next = rep + REP_W'(1);
      end
    end
    rct_trip = raw_valid && (rep_next == REP_W'(RCT_LIMIT));
  end

  // Health state: rep and the previous raw bit advance only on raw samples; the failure flag is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep         <= '0;
      prev_raw    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (raw_valid) begin
        rep      <= rep_next;
        prev_raw <= raw_bit;
      end
      if (rct_trip) begin
        health_fail <= 1'b1;
      end
    end
  end

  // Output handshake qualifiers; a word load outranks shifting in a new bit.
  always_comb begin
    acc_full = (cnt == CNT_W'(WIDTH));
    xfer     = out_valid && out_ready;
    kill     = health_fail || rct_trip;
    load     = acc_full && (!out_valid || xfer) && !kill;
  end

  // Accumulator and output word register.
  // Health failure wins over everything, then a load; a bit arriving while the
  // accumulator is full is simply discarded so a held word is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (kill) begin
      out_valid <= 1'b0;
      cnt       <= '0;
    end else if (load) begin
      out_data  <= acc;
      out_valid <= 1'b1;
      cnt       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b0;
      end
      if (emit_valid && !acc_full) begin
        acc <= {acc[WIDTH-2:0], emit_bit};
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_trng_sampler.sv
// tb_trng_sampler: directed self-checking bench for trng_sampler.
// u_dut1 (one channel) exercises debiasing, packing, backpressure, health and reset;
// u_dut2 (two channels) exercises the XOR combine feeding the health test.
module tb_trng_sampler;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b1;
  logic       en1 = 1'b0;
  logic [0:0] ro1 = '0;
  logic [7:0] data1;
  logic       valid1;
  logic       ready1 = 1'b1;
  logic       fail1;

  logic       rst2 = 1'b1;
  logic       en2 = 1'b0;
  logic [1:0] ro2 = '0;
  logic [7:0] data2;
  logic       valid2;
  logic       ready2 = 1'b1;
  logic       fail2;

  trng_sampler #(.N_CH(1), .WIDTH(8), .SYNC_STAGES(2), .RCT_LIMIT(32)) u_dut1 (
    .clk(clk), .rst(rst1), .en(en1), .ro_in(ro1),
    .out_data(data1), .out_valid(valid1), .out_ready(ready1), .health_fail(fail1)
  );

  trng_sampler #(.N_CH(2), .WIDTH(8), .SYNC_STAGES(2), .RCT_LIMIT(32)) u_dut2 (
    .clk(clk), .rst(rst2), .en(en2), .ro_in(ro2),
    .out_data(data2), .out_valid(valid2), .out_ready(ready2), .health_fail(fail2)
  );

  int         checks = 0;
  int         errors = 0;
  int         words = 0;
  int         valid_cycles = 0;
  logic [7:0] last_word = '0;
  bit         sq[$];
  logic       tog = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Words accepted by the consumer, observed mid-cycle before the transferring edge.
  always @(negedge clk) begin
    if (!rst1) begin
      if (valid1) valid_cycles++;
      if (valid1 && ready1) begin
        words++;
        last_word = data1;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset1();
    rst1 = 1'b1;
    en1  = 1'b0;
    tick(2);
    rst1 = 1'b0;
    words = 0;
    valid_cycles = 0;
  endtask

  // Queue n debiased bits (MSB first) as raw pairs b,~b.
  task automatic push_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sq.push_back(v[i]);
      sq.push_back(~v[i]);
    end
  endtask

  task automatic push_raw(input bit b);
    sq.push_back(b);
  endtask

  // Drive the queued raw bits; en rises exactly when the first one reaches raw_bit
  // (3 cycles of sync+raw latency), so the corrector starts on a pair boundary.
  task automatic run_stream();
    int n;
    n = sq.size();
    for (int i = 0; i < n + 3; i++) begin
      @(posedge clk);
      #1;
      ro1 = (i < n) ? sq[i] : 1'b0;
      en1 = (i >= 3);
    end
    @(posedge clk);
    #1;
    en1 = 1'b0;
    sq.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state of both instances
    tick(2);
    rst1 = 1'b0;
    rst2 = 1'b0;
    #0;
    check("rst_data1",  data1,  8'h00);
    check("rst_valid1", valid1, 1'b0);
    check("rst_fail1",  fail1,  1'b0);
    check("rst_data2",  data2,  8'h00);
    check("rst_valid2", valid2, 1'b0);
    check("rst_fail2",  fail2,  1'b0);

    // 1: eight 10 pairs -> one word FF, valid for exactly one cycle
    reset1();
    ready1 = 1'b1;
    push_bits(8'hFF, 8);
    run_stream();
    tick(4);
    check("t1_words",  words, 1);
    check("t1_word",   last_word, 8'hFF);
    check("t1_vcyc",   valid_cycles, 1);
    check("t1_valid",  valid1, 1'b0);

    // 2: equal pairs emit nothing; accumulator survives en gaps
    reset1();
    for (int k = 0; k < 2; k++) begin
      push_raw(0); push_raw(1); push_raw(0); push_raw(0);
      push_raw(0); push_raw(1); push_raw(1); push_raw(1);
    end
    run_stream();
    tick(4);
    check("t2_nowords", words, 0);
    push_bits(8'h00, 4);
    run_stream();
    tick(4);
    check("t2_words", words, 1);
    check("t2_word",  last_word, 8'h00);

    // 3: backpressure holds A5, buffers 3C, drops the third byte
    reset1();
    ready1 = 1'b0;
    push_bits(8'hA5, 8);
    push_bits(8'h3C, 8);
    push_bits(8'hFF, 8);
    run_stream();
    tick(2);
    check("t3_valid", valid1, 1'b1);
    check("t3_data",  data1, 8'hA5);
    tick(5);
    check("t3_hold",  data1, 8'hA5);
    check("t3_none",  words, 0);
    ready1 = 1'b1;
    tick(1);
    ready1 = 1'b0;
    check("t3_w1",     last_word, 8'hA5);
    check("t3_next",   data1, 8'h3C);
    check("t3_nvalid", valid1, 1'b1);
    ready1 = 1'b1;
    tick(1);
    ready1 = 1'b0;
    check("t3_w2",    last_word, 8'h3C);
    check("t3_drop",  valid1, 1'b0);
    tick(5);
    check("t3_cnt",   words, 2);
    check("t3_idle",  valid1, 1'b0);

    // 4: stuck-at-0 source trips RCT, clears a pending word, stays tripped until rst
    reset1();
    ready1 = 1'b0;
    push_bits(8'hFF, 8);
    run_stream();
    en1 = 1'b1;
    tick(30);
    check("t4_prefail", fail1, 1'b0);
    check("t4_pend",    valid1, 1'b1);
    tick(1);
    check("t4_fail",    fail1, 1'b1);
    check("t4_vclr",    valid1, 1'b0);
    ready1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_bits(8'h5A, 8);
    end
    run_stream();
    tick(130);
    check("t4_nowords", words, 0);
    check("t4_sticky",  fail1, 1'b1);
    check("t4_novalid", valid1, 1'b0);
    reset1();
    check("t4_rstclr",  fail1, 1'b0);

    // 5: two channels toggling together -> raw 0; inverted -> raw 1 (3-cycle fill)
    rst2 = 1'b1;
    tick(2);
    tog = 1'b0;
    ro2 = {tog, tog};
    rst2 = 1'b0;
    en2  = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick(1);
      tog = ~tog;
      ro2 = {tog, tog};
      if (k == 31) check("t5a_pre", fail2, 1'b0);
    end
    check("t5a_fail", fail2, 1'b1);
    rst2 = 1'b1;
    en2  = 1'b0;
    tick(2);
    ro2 = {~tog, tog};
    rst2 = 1'b0;
    en2  = 1'b1;
    #0;
    check("t5b_rst", fail2, 1'b0);
    for (int k = 1; k <= 35; k++) begin
      tick(1);
      tog = ~tog;
      ro2 = {~tog, tog};
      if (k == 34) check("t5b_pre", fail2, 1'b0);
    end
    check("t5b_fail",  fail2, 1'b1);
    check("t5b_valid", valid2, 1'b0);
    en2 = 1'b0;

    // 6a: reset after 5 of 8 bits discards the partial word
    reset1();
    ready1 = 1'b1;
    push_bits(8'h1F, 5);
    run_stream();
    tick(2);
    check("t6_part", words, 0);
    rst1 = 1'b1;
    tick(1);
    rst1 = 1'b0;
    push_bits(8'h02, 3);
    run_stream();
    tick(4);
    check("t6_wait",  words, 0);
    push_bits(8'h1A, 5);
    run_stream();
    tick(4);
    check("t6_words", words, 1);
    check("t6_word",  last_word, 8'h5A);

    // 6b: en drops after an odd raw bit; pairing restarts, accumulator kept
    reset1();
    push_bits(8'h0A, 4);
    push_raw(1);
    run_stream();
    tick(2);
    check("t6b_none", words, 0);
    push_bits(8'h05, 4);
    run_stream();
    tick(4);
    check("t6b_words", words, 1);
    check("t6b_word",  last_word, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
